softmax_div_sched: RTL

//  Sequences one normalisation job through the shared 64/32 pipelined unsigned divider.

---
 rtl/softmax_div_sched.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/softmax_div_sched.sv
// Schedules one softmax normalisation job through a shared pipelined 64/32 divider.
// Tags follow operands through the divider, and the pipe stalls instead of dropping a result.
module softmax_div_sched #(
    parameter int A_W        = 64,
    parameter int B_W        = 32,
    parameter int NUM_STAGES = 64,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [B_W-1:0]   divisor,
    output logic             busy,
    output logic             done,
    output logic             err_div0,
    input  logic             in_valid,
    input  logic [A_W-1:0]   in_data,
    output logic             in_ready,
    output logic             div_en,
    output logic [A_W-1:0]   div_a,
    output logic [B_W-1:0]   div_b,
    input  logic [A_W-1:0]   div_quotient,
    output logic             out_valid,
    output logic [A_W-1:0]   out_data,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int L = NUM_STAGES - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] retired_q, retired_d;
    logic [B_W-1:0]   divisor_q, divisor_d;
    logic             err_div0_q, err_div0_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [L-1:0]     tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [A_W-1:0]   out_data_q, out_data_d;

    logic             stall_s;
    logic             en_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             retire_s;
    logic             out_fire_s;

    // A result due out of the divider while the output register is still held must freeze the pipe.
    always_comb begin
        stall_s    = out_valid_q & ~out_ready & tag_q[L-1];
        en_s       = ~stall_s;
        in_ready_s = (state_q == S_RUN) & (issued_q < len_q) & en_s;
        accept_s   = in_valid & in_ready_s;
        retire_s   = en_s & tag_q[L-1];
        out_fire_s = out_valid_q & out_ready;
    end

    // Job sequencing and issue/retire bookkeeping.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        divisor_d  = divisor_q;
        err_div0_d = err_div0_q;
        issued_d   = issued_q;
        retired_d  = retired_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = len;
                    divisor_d  = divisor;
                    err_div0_d = (divisor == {B_W{1'b0}});
                    issued_d   = {LEN_W{1'b0}};
                    retired_d  = {LEN_W{1'b0}};
                    if (len == {LEN_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s) begin
                    issued_d = issued_q + LEN_W'(1);
                end else begin
                    issued_d = issued_q;
                end
                if (retire_s) begin
                    retired_d = retired_q + LEN_W'(1);
                end else begin
                    retired_d = retired_q;
                end
                if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (retire_s) begin
                    retired_d = retired_q + LEN_W'(1);
                end else begin
                    retired_d = retired_q;
                end
                // Finish only once the last beat has actually left the output register.
                if ((retired_q == len_q) && (!out_valid_q || out_ready)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Tag shift and output register; tags move only when the divider advances.
    always_comb begin
        if (en_s) begin
            tag_d = {tag_q[L-2:0], accept_s};
        end else begin
            tag_d = tag_q;
        end
        if (retire_s) begin
            out_data_d  = div_quotient;
            out_valid_d = 1'b1;
            out_last_d  = ((retired_q + LEN_W'(1)) == len_q);
        end else if (out_fire_s) begin
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_data_d  = out_data_q;
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end
    end

    // State registers; reset drops any in-flight work by clearing the tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= {LEN_W{1'b0}};
            divisor_q   <= {B_W{1'b0}};
            err_div0_q  <= 1'b0;
            issued_q    <= {LEN_W{1'b0}};
            retired_q   <= {LEN_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tag_q       <= {L{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {A_W{1'b0}};
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            divisor_q   <= divisor_d;
            err_div0_q  <= err_div0_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign div_en    = en_s;
    assign div_a     = accept_s ? in_data : {A_W{1'b0}};
    assign div_b     = divisor_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_div0  = err_div0_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule
